// File: rtl/inst_rom_loader.sv
// Instruction ROM for the MIPS fetch port, refillable at run time
// through a big-endian byte-stream loader with valid/ready handshake.
module inst_rom_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rom_enable,
    input  logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  ld_busy,
    output logic [DEPTH_LOG2:0]   ld_word_count,
    output logic                  ld_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    state_t                state;
    logic [DEPTH_LOG2:0]   wptr;
    logic [1:0]            bidx;
    logic [31:0]           acc;
    logic                  err;
    logic [31:0]           word;
    logic                  accept;
    logic                  full;
    logic                  wr_en;
    logic [31:0]           mem [DEPTH];
    logic                  unused_addr;

    assign unused_addr = ^{rom_addr[ADDR_WIDTH-1:DEPTH_LOG2+2], rom_addr[1:0]};

    assign ld_ready      = (state == LOAD) && !ld_start;
    assign ld_busy       = (state == LOAD);
    assign ld_word_count = wptr;
    assign ld_err        = err;

    assign accept = ld_valid && ld_ready;
    assign full   = wptr[DEPTH_LOG2];
    assign wr_en  = accept && !full && ((bidx == 2'd3) || ld_last);

    // Unfilled low bytes read as zero, which gives the padding for a short last word.
    always_comb begin
        word = (bidx == 2'd0) ? 32'h0 : acc;
        unique case (bidx)
            2'd0: word[31:24] = ld_byte;
            2'd1: word[23:16] = ld_byte;
            2'd2: word[15:8]  = ld_byte;
            2'd3: word[7:0]   = ld_byte;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[DEPTH_LOG2-1:0]] <= word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wptr  <= '0;
            bidx  <= 2'd0;
            acc   <= 32'h0;
            err   <= 1'b0;
        end else if (ld_start) begin
            state <= LOAD;
            wptr  <= '0;
            bidx  <= 2'd0;
            acc   <= 32'h0;
            err   <= 1'b0;
        end else if (accept) begin
            acc  <= word;
            bidx <= bidx + 2'd1;
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (full || (ld_last && (bidx != 2'd3))) begin
                err <= 1'b1;
            end
            if (ld_last) begin
                state <= IDLE;
                bidx  <= 2'd0;
            end
        end
    end

    assign rom_data = ((state == IDLE) && rom_enable)
                    ? mem[rom_addr[DEPTH_LOG2+1:2]] : '0;

endmodule
